// File: rtl/demux1to2_stream_if.sv
// Handshake bundle for demux1to2_stream: one valid/ready input stream and two valid/ready output streams.
// master = producer/consumer side, slave = demux side.
interface demux1to2_stream_if #(
  parameter int K = 24
);
  logic [K-1:0] d;
  logic         sel;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] oa;
  logic         valid_a;
  logic         ready_a;
  logic [K-1:0] ob;
  logic         valid_b;
  logic         ready_b;

  modport master (
    output d, sel, in_valid, ready_a, ready_b,
    input  in_ready, oa, valid_a, ob, valid_b
  );

  modport slave (
    input  d, sel, in_valid, ready_a, ready_b,
    output in_ready, oa, valid_a, ob, valid_b
  );
endinterface

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demux: each accepted word is steered by sel into per-channel FIFO A (sel=0) or B (sel=1).
// Optional macro DEMUX_CNT_EN adds 16-bit wrapping pop counters cnt_a/cnt_b.
module demux1to2_stream #(
  parameter int K     = 24,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux1to2_stream_if.slave    bus
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]          cnt_a,
  output logic [15:0]          cnt_b
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]        full;
  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0][K-1:0] head;
  logic              accept;

  // in_ready depends combinationally on sel; a full channel never accepts, even while popping
  assign bus.in_ready = rst_n & ~full[bus.sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = {accept & bus.sel, accept & ~bus.sel};
  assign ready        = {bus.ready_b, bus.ready_a};
  assign pop          = valid & ready;

  assign bus.oa      = head[0];
  assign bus.ob      = head[1];
  assign bus.valid_a = valid[0];
  assign bus.valid_b = valid[1];

`ifdef DEMUX_CNT_EN
  logic [1:0][15:0] pop_cnt;
  assign cnt_a = pop_cnt[0];
  assign cnt_b = pop_cnt[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [K-1:0]  mem_reg [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic [AW:0]   count_next;

      always_comb begin
        count_next = count_reg;
        if (push[gi] && !pop[gi]) begin
          count_next = count_reg + 1'b1;
        end else if (!push[gi] && pop[gi]) begin
          count_next = count_reg - 1'b1;
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_next;
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem_reg[wr_ptr_reg] <= bus.d;
      end

      assign full[gi]  = (count_reg == FULL_CNT);
      assign valid[gi] = (count_reg != '0);
      assign head[gi]  = valid[gi] ? mem_reg[rd_ptr_reg] : '0;

`ifdef DEMUX_CNT_EN
      logic [15:0] pop_cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pop_cnt_reg <= '0;
        end else if (pop[gi]) begin
          pop_cnt_reg <= pop_cnt_reg + 16'd1;
        end
      end

      assign pop_cnt[gi] = pop_cnt_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream; hand-computed expectations, one line per checked value.
// Define DEMUX_CNT_EN to also exercise the pop counters.
module tb_demux1to2_stream;
  localparam int K = 24;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  demux1to2_stream_if #(.K(K)) bus ();

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  demux1to2_stream #(.K(K), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.d        = '0;
    bus.sel      = 1'b0;
    bus.in_valid = 1'b0;
    bus.ready_a  = 1'b0;
    bus.ready_b  = 1'b0;

    // Reset then idle
    tick();
    check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_valid_a", 32'(bus.valid_a), 32'd0);
    check("rst_valid_b", 32'(bus.valid_b), 32'd0);
    check("rst_oa", 32'(bus.oa), 32'd0);
    check("rst_ob", 32'(bus.ob), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single route to B
    bus.d = 24'hABCDEF; bus.sel = 1'b1; bus.in_valid = 1'b1; bus.ready_b = 1'b1;
    #1;
    check("route_in_ready", 32'(bus.in_ready), 32'd1);
    check("route_valid_b_before", 32'(bus.valid_b), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("route_valid_b", 32'(bus.valid_b), 32'd1);
    check("route_ob", 32'(bus.ob), 32'hABCDEF);
    check("route_valid_a", 32'(bus.valid_a), 32'd0);
    tick();
    check("route_valid_b_after", 32'(bus.valid_b), 32'd0);
    check("route_ob_after", 32'(bus.ob), 32'd0);
    check("route_valid_a_after", 32'(bus.valid_a), 32'd0);

    // Backpressure / full on A
    bus.ready_a = 1'b0; bus.sel = 1'b0; bus.in_valid = 1'b1; bus.d = 24'h000001;
    tick();
    bus.d = 24'h000002;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("bp_in_ready_sel0", 32'(bus.in_ready), 32'd0);
    bus.sel = 1'b1;
    #1;
    check("bp_in_ready_sel1", 32'(bus.in_ready), 32'd1);
    check("bp_oa_head", 32'(bus.oa), 32'h1);
    bus.sel = 1'b0; bus.ready_a = 1'b1;
    tick();
    check("bp_oa_second", 32'(bus.oa), 32'h2);
    check("bp_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_valid_a_drained", 32'(bus.valid_a), 32'd0);
    bus.ready_a = 1'b0;

    // Independent channels: A full and stalled while B streams
    bus.sel = 1'b0; bus.in_valid = 1'b1; bus.d = 24'h0000A1;
    tick();
    bus.d = 24'h0000A2;
    tick();
    bus.sel = 1'b1; bus.ready_b = 1'b1; bus.d = 24'h000100;
    #1;
    check("ind_in_ready_b", 32'(bus.in_ready), 32'd1);
    tick();
    check("ind_ob_100", 32'(bus.ob), 32'h100);
    bus.d = 24'h000101;
    tick();
    check("ind_ob_101", 32'(bus.ob), 32'h101);
    check("ind_valid_b_101", 32'(bus.valid_b), 32'd1);
    bus.d = 24'h000102;
    tick();
    check("ind_ob_102", 32'(bus.ob), 32'h102);
    bus.in_valid = 1'b0;
    tick();
    check("ind_valid_b_end", 32'(bus.valid_b), 32'd0);
    check("ind_oa_unchanged", 32'(bus.oa), 32'hA1);
    bus.sel = 1'b0;
    #1;
    check("ind_a_still_full", 32'(bus.in_ready), 32'd0);
    bus.ready_a = 1'b1;
    tick();
    check("ind_oa_a2", 32'(bus.oa), 32'hA2);
    tick();
    check("ind_a_drained", 32'(bus.valid_a), 32'd0);
    bus.ready_a = 1'b0; bus.ready_b = 1'b0;

    // Simultaneous push and pop on A
    bus.sel = 1'b0; bus.in_valid = 1'b1; bus.d = 24'h00000A;
    tick();
    bus.d = 24'h00000B; bus.ready_a = 1'b1;
    #1;
    check("sim_oa_0a", 32'(bus.oa), 32'hA);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("sim_oa_0b", 32'(bus.oa), 32'hB);
    check("sim_valid_a", 32'(bus.valid_a), 32'd1);
    tick();
    check("sim_single_left", 32'(bus.valid_a), 32'd0);
    bus.ready_a = 1'b0;

    // Full with pop: no push-through
    bus.in_valid = 1'b1; bus.d = 24'h000031;
    tick();
    bus.d = 24'h000032;
    tick();
    bus.d = 24'h000033; bus.ready_a = 1'b1;
    #1;
    check("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_valid = 1'b0; bus.ready_a = 1'b0;
    #1;
    check("full_pop_oa", 32'(bus.oa), 32'h32);

    // Fill both channels, then reset mid-operation
    bus.sel = 1'b1; bus.in_valid = 1'b1; bus.d = 24'h000041;
    tick();
    bus.d = 24'h000042;
    tick();
    bus.sel = 1'b0; bus.d = 24'h000034;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("both_full_sel0", 32'(bus.in_ready), 32'd0);
    bus.sel = 1'b1;
    #1;
    check("both_full_sel1", 32'(bus.in_ready), 32'd0);
    check("both_full_ob", 32'(bus.ob), 32'h41);
`ifdef DEMUX_CNT_EN
    check("cnt_a_before_rst", 32'(cnt_a), 32'd7);
    check("cnt_b_before_rst", 32'(cnt_b), 32'd4);
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid_a", 32'(bus.valid_a), 32'd0);
    check("mid_rst_valid_b", 32'(bus.valid_b), 32'd0);
    check("mid_rst_oa", 32'(bus.oa), 32'd0);
    check("mid_rst_ob", 32'(bus.ob), 32'd0);
    check("mid_rst_in_ready_out", 32'(bus.in_ready), 32'd1);
`ifdef DEMUX_CNT_EN
    check("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("mid_rst_cnt_b", 32'(cnt_b), 32'd0);

    // Stream on A: first edge only pushes, every later edge pushes and pops
    bus.sel = 1'b0; bus.in_valid = 1'b1; bus.ready_a = 1'b1; bus.d = 24'h000055;
    for (int i = 0; i < 65536; i++) tick();
    check("cnt_a_ffff", 32'(cnt_a), 32'hFFFF);
    tick();
    check("cnt_a_wrap", 32'(cnt_a), 32'd0);
    check("cnt_b_idle", 32'(cnt_b), 32'd0);
    bus.in_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
